// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default build gives data fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  localparam int BWIDTH = DWIDTH / 8;

  arb_state_e r_state;
  arb_state_e w_next_state;
  req_id_e    w_winner;
  logic       w_any_req;

  assign w_any_req = if_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  req_id_e r_last_gnt;
  logic    w_accept;

  assign w_accept = rst_n && (r_state == IDLE) && w_any_req && mem_gnt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= REQ_D;
    end else if (w_accept) begin
      r_last_gnt <= w_winner;
    end
  end
`endif

  // On a tie the default build favours data; round-robin favours whoever was not served last.
  always_comb begin
    w_winner = REQ_D;
    if (if_req_i && !d_req_i) begin
      w_winner = REQ_IF;
    end else if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      w_winner = (r_last_gnt == REQ_D) ? REQ_IF : REQ_D;
`else
      w_winner = REQ_D;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are gated by rst_n so every port reads 0 for the whole reset window.
  always_comb begin
    w_next_state = r_state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;
    if_gnt_o     = 1'b0;
    d_gnt_o      = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    d_rvalid_o   = 1'b0;
    d_rdata_o    = '0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            mem_req_o = 1'b1;
            if (w_winner == REQ_D) begin
              mem_we_o    = d_we_i;
              mem_addr_o  = d_addr_i;
              mem_wdata_o = d_wdata_i;
              mem_be_o    = d_be_i;
              d_gnt_o     = mem_gnt_i;
              if (mem_gnt_i) begin
                w_next_state = WAIT_D;
              end
            end else begin
              mem_addr_o = if_addr_i;
              mem_be_o   = {BWIDTH{1'b1}};
              if_gnt_o   = mem_gnt_i;
              if (mem_gnt_i) begin
                w_next_state = WAIT_IF;
              end
            end
          end
        end
        WAIT_IF: begin
          if (mem_rvalid_i) begin
            if_rvalid_o  = 1'b1;
            if_rdata_o   = mem_rdata_i;
            w_next_state = IDLE;
          end
        end
        WAIT_D: begin
          if (mem_rvalid_i) begin
            d_rvalid_o   = 1'b1;
            d_rdata_o    = mem_rdata_i;
            w_next_state = IDLE;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic against a transaction-level model.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0, d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [BW-1:0] d_be_i = '0;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  int numChecks = 0;
  int numFails  = 0;

  // Transaction-level model: is a transfer in flight, who owns it, who was served last.
  bit mBusy   = 1'b0;
  bit mOwnerD = 1'b0;
  bit mLastD  = 1'b1;

  bit lastIfGnt = 1'b0, lastDGnt = 1'b0, lastAccept = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  function automatic bit winnerIsD();
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      return !mLastD;
`else
      return 1'b1;
`endif
    end
    return d_req_i;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit ifReq, input logic [AW-1:0] ifAddr,
                               input bit dReq, input bit dWe, input logic [AW-1:0] dAddr,
                               input logic [DW-1:0] dWdata, input logic [BW-1:0] dBe,
                               input bit memGnt, input bit memRvalid, input logic [DW-1:0] memRdata);
    @(posedge clk);
    #1;
    if_req_i     = ifReq;
    if_addr_i    = ifAddr;
    d_req_i      = dReq;
    d_we_i       = dWe;
    d_addr_i     = dAddr;
    d_wdata_i    = dWdata;
    d_be_i       = dBe;
    mem_gnt_i    = memGnt;
    mem_rvalid_i = memRvalid;
    mem_rdata_i  = memRdata;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy  <= 1'b0;
      mLastD <= 1'b1;
    end else if (!mBusy) begin
      if ((if_req_i || d_req_i) && mem_gnt_i) begin
        mBusy   <= 1'b1;
        mOwnerD <= winnerIsD();
        mLastD  <= winnerIsD();
      end
    end else if (mem_rvalid_i) begin
      mBusy <= 1'b0;
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    bit expReq, winD, rvIf, rvD;
    if (!rst_n) begin
      checkOutput("rst_mem_req", mem_req_o, 0);
      checkOutput("rst_gnts", {if_gnt_o, d_gnt_o}, 0);
      checkOutput("rst_rvalids", {if_rvalid_o, d_rvalid_o}, 0);
      checkOutput("rst_mem_fields", {mem_we_o, mem_be_o, mem_addr_o}, 0);
      checkOutput("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
    end else begin
      expReq = !mBusy && (if_req_i || d_req_i);
      winD   = winnerIsD();
      checkOutput("mem_req", mem_req_o, expReq);
      if (expReq) begin
        checkOutput("mem_addr", mem_addr_o, winD ? d_addr_i : if_addr_i);
        checkOutput("mem_we", mem_we_o, winD ? d_we_i : 1'b0);
        checkOutput("mem_be", mem_be_o, winD ? d_be_i : {BW{1'b1}});
        if (winD) checkOutput("mem_wdata", mem_wdata_o, d_wdata_i);
      end
      checkOutput("if_gnt", if_gnt_o, expReq && !winD && mem_gnt_i);
      checkOutput("d_gnt", d_gnt_o, expReq && winD && mem_gnt_i);
      rvIf = mBusy && !mOwnerD && mem_rvalid_i;
      rvD  = mBusy && mOwnerD && mem_rvalid_i;
      checkOutput("if_rvalid", if_rvalid_o, rvIf);
      checkOutput("d_rvalid", d_rvalid_o, rvD);
      checkOutput("if_rdata", if_rdata_o, rvIf ? mem_rdata_i : '0);
      checkOutput("d_rdata", d_rdata_o, rvD ? mem_rdata_i : '0);
    end
    lastIfGnt  = if_gnt_o;
    lastDGnt   = d_gnt_o;
    lastAccept = mem_req_o && mem_gnt_i;
  end

  initial begin
    bit expOrderD [4];
    bit pending;
    int rspDelay;
`ifdef MEM_ARB_RR_EN
    expOrderD = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    expOrderD = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // Reset with requests and a response active: every output must stay 0.
    applyStimulus(1, 32'h40, 1, 1, 32'h80, 32'h1234, 4'hF, 1, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("reset_mem_req", mem_req_o, 0);
    checkOutput("reset_d_gnt", d_gnt_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Fetch: grant in cycle 0, response in cycle 2.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("fetch_gnt_c0", if_gnt_o, 1);
    checkOutput("fetch_addr_c0", mem_addr_o, 32'h100);
    checkOutput("fetch_be_c0", mem_be_o, 4'hF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("fetch_wait_req_c1", mem_req_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    @(negedge clk);
    checkOutput("fetch_rvalid_c2", if_rvalid_o, 1);
    checkOutput("fetch_rdata_c2", if_rdata_o, 32'h0000_0013);

    // Store with partial byte enables, acknowledged one cycle later.
    applyStimulus(0, 0, 1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 1, 0, 0);
    @(negedge clk);
    checkOutput("store_we", mem_we_o, 1);
    checkOutput("store_be", mem_be_o, 4'b0011);
    checkOutput("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    checkOutput("store_gnt", d_gnt_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    @(negedge clk);
    checkOutput("store_ack", d_rvalid_o, 1);

    // Fresh reset so the last-grant history starts at data.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h1000 + k, 1, 0, 32'h2000 + k, 0, 4'hF, 1, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("order_d_gnt_%0d", k), d_gnt_o, expOrderD[k]);
      checkOutput($sformatf("order_if_gnt_%0d", k), if_gnt_o, !expOrderD[k]);
      applyStimulus(1, 32'h1000 + k, 1, 0, 32'h2000 + k, 0, 4'hF, 1, 1, 32'hA0 + k);
      @(negedge clk);
      checkOutput($sformatf("order_d_rvalid_%0d", k), d_rvalid_o, expOrderD[k]);
    end

    // Memory stalls the grant for three cycles; request and fields must hold.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 1, 0, 32'h300, 0, 4'hF, c == 3, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("stall_req_c%0d", c), mem_req_o, 1);
      checkOutput($sformatf("stall_addr_c%0d", c), mem_addr_o, 32'h300);
      checkOutput($sformatf("stall_d_gnt_c%0d", c), d_gnt_o, c == 3);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);

    // Reset abandons an outstanding load; the late response is ignored.
    applyStimulus(0, 0, 1, 0, 32'h400, 0, 4'hF, 1, 0, 0);
    @(negedge clk);
    checkOutput("abandon_d_gnt", d_gnt_o, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 32'hABCD);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abandon_d_rvalid", d_rvalid_o, 0);
    checkOutput("abandon_d_rdata", d_rdata_o, 0);
    checkOutput("abandon_idle_req", mem_req_o, 1);

    // Spurious response while idle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("spurious_rvalids", {if_rvalid_o, d_rvalid_o}, 0);
    checkOutput("spurious_if_rdata", if_rdata_o, 0);
    checkOutput("spurious_d_rdata", d_rdata_o, 0);

    // Randomized traffic; the compare process checks every cycle.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pending  = 1'b0;
    rspDelay = 0;
    repeat (3000) begin
      @(posedge clk);
      #1;
      if (!if_req_i || lastIfGnt) begin
        if_req_i  = ($urandom_range(0, 99) < 55);
        if_addr_i = $urandom;
      end
      if (!d_req_i || lastDGnt) begin
        d_req_i   = ($urandom_range(0, 99) < 55);
        d_we_i    = $urandom_range(0, 1);
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
        d_be_i    = BW'($urandom);
      end
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rdata_i  = $urandom;
      mem_rvalid_i = 1'b0;
      if (lastAccept) begin
        pending  = 1'b1;
        rspDelay = $urandom_range(0, 3);
      end
      if (pending) begin
        if (rspDelay == 0) begin
          mem_rvalid_i = 1'b1;
          pending      = 1'b0;
        end else begin
          rspDelay--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        mem_rvalid_i = 1'b1;
      end
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: AWIDTH, default 32, address width; DWIDTH, default 32, data width (multiple of 8).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- if_req_i  in  1  fetch read request
- if_addr_i  in  AWIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DWIDTH  fetch read data
- d_req_i  in  1  load/store request
- d_we_i  in  1  1 = store
- d_addr_i  in  AWIDTH  data address
- d_wdata_i  in  DWIDTH  store data
- d_be_i  in  DWIDTH/8  byte enables
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data valid or store acknowledge
- d_rdata_o  out  DWIDTH  load data
- mem_req_o, mem_we_o  out  1  memory request, write enable
- mem_addr_o  out  AWIDTH  memory address
- mem_wdata_o  out  DWIDTH  memory write data
- mem_be_o  out  DWIDTH/8  memory byte enables
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DWIDTH  memory response data

Function
REQ-003 The block SHALL share one memory port between fetch and data, with at most one transaction outstanding.
REQ-004 The FSM SHALL have states IDLE, WAIT_IF, WAIT_D.
REQ-005 In IDLE with any request pending, the block SHALL select a winner combinationally and drive mem_req_o=1 with the winner's fields; fetch drives mem_we_o=0 and mem_be_o all-ones.
REQ-006 A transaction SHALL be accepted in the cycle where mem_req_o and mem_gnt_i are both 1; the winner's gnt_o SHALL be 1 in that same cycle only; the next state SHALL be WAIT_IF or WAIT_D.
REQ-007 Requesters SHALL hold req and fields stable until gnt; the arbiter SHALL re-arbitrate every IDLE cycle that is not granted.
REQ-008 In WAIT_* the block SHALL hold mem_req_o=0 and all gnt_o=0.
REQ-009 On mem_rvalid_i in WAIT_IF or WAIT_D, the owner's rvalid_o SHALL pulse for 1 cycle (combinational pass-through) with rdata_o=mem_rdata_i, and the FSM SHALL return to IDLE; stores SHALL receive rvalid as acknowledge.
REQ-010 mem_rvalid_i in IDLE SHALL be ignored; no rvalid_o SHALL assert.
REQ-011 Minimum cycle count SHALL be request-to-grant 0 cycles and grant-to-next-grant 2 cycles (grant, response, new grant).
REQ-012 rdata_o SHALL be 0 when the matching rvalid_o is 0.

Reset
REQ-013 While rst_n=0, the FSM SHALL be IDLE, the last-grant register SHALL be set to data, and all outputs SHALL be 0.
REQ-014 Reset in WAIT_* SHALL abandon the outstanding transaction; a late mem_rvalid_i SHALL fall under REQ-010.

Configuration
REQ-015 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last; the last-grant register SHALL update on each accept.
REQ-016 Without MEM_ARB_RR_EN, data SHALL always win over fetch, and the last-grant register SHALL be absent.

Structure
REQ-017 The shared constants package SHALL hold the FSM state enum (arb_state_e) and the requester-id enum (REQ_IF, REQ_D).
REQ-018 The block SHALL be one module with no sub-modules; priority selection is an always_comb block.

Verification
REQ-019 Fetch only, addr 0x100, mem_gnt_i same cycle, rvalid 2 cycles later with 0x00000013 -> if_gnt_o at cycle 0, if_rvalid_o=1 and if_rdata_o=0x00000013 at cycle 2.
REQ-020 Store to 0x200, wdata 0xDEADBEEF, be 4'b0011 -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF; d_rvalid_o on ack.
REQ-021 Both request continuously for 4 transactions -> without the macro, D,D,D,D; with MEM_ARB_RR_EN, IF,D,IF,D (first grant goes to IF because reset sets last-grant to data).
REQ-022 mem_gnt_i held 0 for 3 cycles with d_req_i=1 -> mem_req_o stays 1 with stable fields; d_gnt_o only in cycle 3.
REQ-023 rst_n pulsed low in WAIT_D, then mem_rvalid_i=1 -> FSM in IDLE, no d_rvalid_o.
REQ-024 Spurious mem_rvalid_i in IDLE with rdata 0xFFFFFFFF -> both rvalid_o=0, both rdata_o=0.
